regfile_scan_checker: RTL and testbench
=======================================

// Module: regfile_scan_checker
// PURPOSE
//  Synthesizable self-check unit between processor and regfile. After a run of
//  N clock cycles it takes over regfile read port A and scans every register.
//  Each register is compared against an expected-value ROM.
//  Reports pass/fail, a saturating error count and a per-mismatch strobe, so
//  on-board runs need no simulator.
// PARAMETERS
//  DATA_W      32   register/expected data width
//  NUM_REGS    32   registers scanned (indices 0..NUM_REGS-1)
//  ADDR_W      5    register index width, >= clog2(NUM_REGS)
//  CYC_W       10   width of run-cycle counter and run_cycles port
//  ERR_W       6    width of error_count (saturating)
// PORTS
//  clock        in   1       rising-edge clock
//  reset_n      in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse: begin run (ignored unless IDLE/DONE)
//  run_cycles   in   CYC_W   cycles to let processor run; sampled on start
//  proc_rs1     in   ADDR_W  processor's read-port-A index
//  rs1_out      out  ADDR_W  index driven to regfile port A
//  regA         in   DATA_W  regfile port-A data (combinational read)
//  exp_addr     out  ADDR_W  expected-ROM address
//  exp_data     in   DATA_W  expected-ROM data, 1-cycle synchronous latency
//  proc_hold    out  1       high in SCAN/DONE: processor must stall
//  busy         out  1       high in RUN/SCAN
//  done         out  1       high in DONE until next start
//  pass         out  1       valid with done: error_count==0
//  error_count  out  ERR_W   mismatches this run, saturates at all-ones
//  fail_valid   out  1       1-cycle strobe per mismatch
//  fail_reg     out  ADDR_W  index of mismatching register (with fail_valid)
//  fail_act     out  DATA_W  actual value (with fail_valid)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; busy/done/pass/proc_hold/fail_valid=0,
//    error_count=0, fail_reg/fail_act=0, exp_addr=0, internal counters 0.
//    Reset mid-RUN/SCAN aborts immediately; no partial result is kept.
//  - rs1_out = proc_rs1 in IDLE/RUN; scan index in SCAN/DONE.
//  - FSM: IDLE -start-> RUN; RUN -count==run_cycles-> SCAN;
//    SCAN -last compare-> DONE; DONE -start-> RUN (clears count/error_count).
//  - run_cycles==0: start goes directly to SCAN on the next edge.
//  - RUN: cycle counter increments each edge from 0; leaves at run_cycles edges.
//  - SCAN pipeline: cycle k drives rs1_out=exp_addr=k and registers regA.
//    Cycle k+1 compares registered regA with exp_data.
//    SCAN lasts NUM_REGS+1 cycles; index stops at NUM_REGS-1 (no wrap).
//  - Mismatch: fail_valid=1 for exactly one cycle (cycle after capture) with
//    fail_reg/fail_act; error_count += 1 unless already all-ones.
//  - DONE entered the edge after the final compare; pass = (error_count==0),
//    error_count/pass held stable until next start.
//  - start while busy: ignored. start same edge as last compare: ignored.
//  - Register 0 is compared like any other (regfile guarantees 0).
// CONFIGURATION
//  REGCHK_MASK_EN defined: adds input exp_mask [DATA_W] (same latency as
//    exp_data); mismatch = ((act ^ exp) & exp_mask) != 0; exp_mask=0 means
//    register is don't-care.
//  Not defined: no exp_mask port; mismatch = (act != exp), all bits compared.
// TESTING
//  1 reset_n low mid-SCAN -> all outputs at reset values, rs1_out==proc_rs1.
//  2 run_cycles=3, ROM==regfile contents -> busy 3+33 cycles, done=1, pass=1,
//    error_count=0, no fail_valid.
//  3 ROM r5=7, regfile r5=9 -> one fail_valid, fail_reg=5, fail_act=9,
//    error_count=1, pass=0.
//  4 ERR_W=2, 5 mismatching regs -> error_count saturates at 3, pass=0.
//  5 run_cycles=0; start pulsed again during SCAN -> SCAN entered next edge,
//    second start ignored, single DONE.
//  6 REGCHK_MASK_EN, r7 act=0xFF exp=0x0F mask=0x0F -> no mismatch;
//    mask=0xFF -> fail_reg=7.

Source files
------------

// File: rtl/regfile_scan_checker.sv
// regfile_scan_checker
// On-board self-check unit between a processor and its register file.
// After a start pulse the processor runs for run_cycles clocks. The checker
// then stalls the processor, takes over read port A, and walks every register.
// Each register is compared against an expected-value ROM that has one cycle
// of synchronous read latency. Results are pass/fail, a saturating error
// count and a one-cycle strobe per mismatching register.
//
// Optional feature macro: REGCHK_MASK_EN
//   Defined:   adds input exp_mask (same latency as exp_data). A register is
//              flagged only where a masked bit differs. A zero mask makes that
//              register a don't-care.
//   Undefined: all DATA_W bits are compared.

module regfile_scan_checker #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CYC_W    = 10,
    parameter int ERR_W    = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CYC_W-1:0]  run_cycles,
    input  logic [ADDR_W-1:0] proc_rs1,
    output logic [ADDR_W-1:0] rs1_out,
    input  logic [DATA_W-1:0] regA,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
`ifdef REGCHK_MASK_EN
    input  logic [DATA_W-1:0] exp_mask,
`endif
    output logic              proc_hold,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  error_count,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_reg,
    output logic [DATA_W-1:0] fail_act
);

    // Index of the final register walked during SCAN.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // waiting for start; processor owns port A
        ST_RUN  = 2'd1,  // processor running, cycle counter advancing
        ST_SCAN = 2'd2,  // checker owns port A, walking registers
        ST_DONE = 2'd3   // result held; processor still stalled
    } state_t;

    // FSM state and registered status outputs
    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_hold;

    // Run phase
    logic [CYC_W-1:0]  r_run_target;   // run_cycles captured at start
    logic [CYC_W-1:0]  r_cnt;          // edges spent in RUN so far

    // Scan pipeline
    logic [ADDR_W-1:0] r_scan_idx;     // register index being read this cycle
    logic              r_issued_all;   // last index has already been read
    logic              r_cap_valid;    // r_act holds a value awaiting compare
    logic [ADDR_W-1:0] r_act_idx;      // index that r_act was read from
    logic [DATA_W-1:0] r_act;          // captured register value

    // Result registers
    logic [ERR_W-1:0]  r_err;
    logic              r_fail_valid;
    logic [ADDR_W-1:0] r_fail_reg;
    logic [DATA_W-1:0] r_fail_act;

    // Combinational helpers
    logic              w_start_ok;
    logic              w_cmp_fire;
    logic [DATA_W-1:0] w_diff;
    logic              w_mismatch;
    logic              w_last_cmp;
    logic [ERR_W-1:0]  w_err_next;
    logic [CYC_W-1:0]  w_cnt_next;
    logic              w_own_port;

    // Decode compare/mismatch conditions and next error count for this cycle
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        w_start_ok = 1'b0;
        w_cmp_fire = 1'b0;
        w_diff     = '0;
        w_mismatch = 1'b0;
        w_last_cmp = 1'b0;
        w_err_next = r_err;
        w_cnt_next = r_cnt + CYC_W'(1);
        w_own_port = 1'b0;

        // start is honoured only when no run is in progress
        w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

        // A compare happens the cycle after a register value was captured;
        // exp_data for that same index arrives in this cycle as well.
        w_cmp_fire = (r_state == ST_SCAN) && r_cap_valid;

`ifdef REGCHK_MASK_EN
        w_diff = (r_act ^ exp_data) & exp_mask;
`else
        w_diff = r_act ^ exp_data;
`endif

        w_mismatch = w_cmp_fire && (|w_diff);
        w_last_cmp = w_cmp_fire && (r_act_idx == LAST_IDX);

        // Saturating increment: once all-ones the count stays put
        if (w_mismatch && !(&r_err)) begin
            w_err_next = r_err + ERR_W'(1);
        end

        w_own_port = (r_state == ST_SCAN) || (r_state == ST_DONE);
    end

    // Port A mux: processor index until the checker takes over the port
    always_comb begin
        rs1_out = proc_rs1;
        if (w_own_port) begin
            rs1_out = r_scan_idx;
        end
    end

    // Main FSM: run counting, scan pipeline and registered result outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the capture/result datapath is reset too, not just control,
            // because fail_reg/fail_act and the counters are visible outputs
            // whose post-reset value must be 0 and no partial run may survive.
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_hold       <= 1'b0;
            r_run_target <= '0;
            r_cnt        <= '0;
            r_scan_idx   <= '0;
            r_issued_all <= 1'b0;
            r_cap_valid  <= 1'b0;
            r_act_idx    <= '0;
            r_act        <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_reg   <= '0;
            r_fail_act   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side reads the pre-edge value regardless of statement order.
            r_fail_valid <= 1'b0;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_run_target <= run_cycles;
                        r_cnt        <= '0;
                        r_err        <= '0;
                        r_pass       <= 1'b0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_scan_idx   <= '0;
                        r_issued_all <= 1'b0;
                        r_cap_valid  <= 1'b0;
                        if (run_cycles == '0) begin
                            // Zero-length run: straight into the scan
                            r_state <= ST_SCAN;
                            r_hold  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_hold  <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == r_run_target) begin
                        r_state <= ST_SCAN;
                        r_hold  <= 1'b1;
                    end
                end

                ST_SCAN: begin
                    // Read stage: capture port A and advance the index,
                    // holding at the last register instead of wrapping.
                    if (!r_issued_all) begin
                        r_act       <= regA;
                        r_act_idx   <= r_scan_idx;
                        r_cap_valid <= 1'b1;
                        if (r_scan_idx == LAST_IDX) begin
                            r_issued_all <= 1'b1;
                        end else begin
                            r_scan_idx <= r_scan_idx + ADDR_W'(1);
                        end
                    end else begin
                        r_cap_valid <= 1'b0;
                    end

                    // Compare stage: report the previous capture
                    if (w_cmp_fire) begin
                        r_err <= w_err_next;
                        if (w_mismatch) begin
                            r_fail_valid <= 1'b1;
                            r_fail_reg   <= r_act_idx;
                            r_fail_act   <= r_act;
                        end
                    end

                    // Final compare closes the run; pass reflects the count
                    // including this last compare.
                    if (w_last_cmp) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_pass      <= (w_err_next == '0);
                        r_cap_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    assign exp_addr    = r_scan_idx;
    assign proc_hold   = r_hold;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign error_count = r_err;
    assign fail_valid  = r_fail_valid;
    assign fail_reg    = r_fail_reg;
    assign fail_act    = r_fail_act;

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Directed bench for regfile_scan_checker. Two instances share a register
// file model: dut1 uses the default widths, dut2 has ERR_W=2 to exercise
// error_count saturation. Each instance has its own synchronous ROM model.

module tb_regfile_scan_checker;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int CW = 10;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start1 = 1'b0;
    logic          start2 = 1'b0;
    logic [CW-1:0] run_cycles = '0;
    logic [AW-1:0] proc_rs1 = 5'd13;

    logic [DW-1:0] reg_mem  [NR];
    logic [DW-1:0] rom      [NR];
    logic [DW-1:0] mask_rom [NR];

    // dut1 signals
    logic [AW-1:0] rs1_out1, exp_addr1, fail_reg1;
    logic [DW-1:0] regA1, fail_act1;
    logic [DW-1:0] exp_data1 = '0;
    logic [DW-1:0] exp_mask1 = '1;
    logic          proc_hold1, busy1, done1, pass1, fail_valid1;
    logic [5:0]    error_count1;

    // dut2 signals
    logic [AW-1:0] rs1_out2, exp_addr2, fail_reg2;
    logic [DW-1:0] regA2, fail_act2;
    logic [DW-1:0] exp_data2 = '0;
    logic [DW-1:0] exp_mask2 = '1;
    logic          proc_hold2, busy2, done2, pass2, fail_valid2;
    logic [1:0]    error_count2;

    int n_vec = 0;
    int n_err = 0;

    // Results gathered by wait_done
    int            busy_cnt;
    int            fail_cnt1;
    int            fail_cnt2;
    logic [AW-1:0] last_reg1;
    logic [DW-1:0] last_act1;
    bit            timed_out;

    always #5 clock = ~clock;

    // Register file: combinational read on port A
    assign regA1 = reg_mem[rs1_out1];
    assign regA2 = reg_mem[rs1_out2];

    // Expected ROMs: one cycle of synchronous latency
    always @(posedge clock) begin
        exp_data1 <= rom[exp_addr1];
        exp_data2 <= rom[exp_addr2];
        exp_mask1 <= mask_rom[exp_addr1];
        exp_mask2 <= mask_rom[exp_addr2];
    end

    regfile_scan_checker dut1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start1),
        .run_cycles  (run_cycles),
        .proc_rs1    (proc_rs1),
        .rs1_out     (rs1_out1),
        .regA        (regA1),
        .exp_addr    (exp_addr1),
        .exp_data    (exp_data1),
`ifdef REGCHK_MASK_EN
        .exp_mask    (exp_mask1),
`endif
        .proc_hold   (proc_hold1),
        .busy        (busy1),
        .done        (done1),
        .pass        (pass1),
        .error_count (error_count1),
        .fail_valid  (fail_valid1),
        .fail_reg    (fail_reg1),
        .fail_act    (fail_act1)
    );

    regfile_scan_checker #(.ERR_W(2)) dut2 (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start2),
        .run_cycles  (run_cycles),
        .proc_rs1    (proc_rs1),
        .rs1_out     (rs1_out2),
        .regA        (regA2),
        .exp_addr    (exp_addr2),
        .exp_data    (exp_data2),
`ifdef REGCHK_MASK_EN
        .exp_mask    (exp_mask2),
`endif
        .proc_hold   (proc_hold2),
        .busy        (busy2),
        .done        (done2),
        .pass        (pass2),
        .error_count (error_count2),
        .fail_valid  (fail_valid2),
        .fail_reg    (fail_reg2),
        .fail_act    (fail_act2)
    );

    // Make the ROM match the register file exactly, all bits significant
    task automatic fill_rom();
        for (int i = 0; i < NR; i++) begin
            rom[i]      = reg_mem[i];
            mask_rom[i] = '1;
        end
    endtask

    // Pulse start on the selected instances; returns at the negedge after
    // the accepting edge.
    task automatic pulse_start(input bit s1, input bit s2, input logic [CW-1:0] rc);
        @(negedge clock);
        run_cycles = rc;
        start1     = s1;
        start2     = s2;
        @(negedge clock);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Sample each negedge until dut1 reports done or the budget runs out
    task automatic wait_done();
        busy_cnt  = 0;
        fail_cnt1 = 0;
        fail_cnt2 = 0;
        last_reg1 = '0;
        last_act1 = '0;
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (busy1) busy_cnt++;
            if (fail_valid1) begin
                fail_cnt1++;
                last_reg1 = fail_reg1;
                last_act1 = fail_act1;
            end
            if (fail_valid2) fail_cnt2++;
            if (done1) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({busy1, done1, pass1, proc_hold1, fail_valid1} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_status: got %b expected 00000", {busy1, done1, pass1, proc_hold1, fail_valid1});
        end
        n_vec++;
        if (error_count1 !== 6'd0) begin
            n_err++;
            $display("FAIL reset_err_count: got %0d expected 0", error_count1);
        end
        n_vec++;
        if ({fail_reg1, fail_act1} !== '0) begin
            n_err++;
            $display("FAIL reset_fail_info: got %0h/%0h expected 0/0", fail_reg1, fail_act1);
        end
        n_vec++;
        if (exp_addr1 !== 5'd0) begin
            n_err++;
            $display("FAIL reset_exp_addr: got %0d expected 0", exp_addr1);
        end
        n_vec++;
        if (rs1_out1 !== 5'd13) begin
            n_err++;
            $display("FAIL reset_rs1_passthru: got %0d expected 13", rs1_out1);
        end
    endtask

    task automatic test_clean_run();
        fill_rom();
        pulse_start(1'b1, 1'b0, 10'd3);
        n_vec++;
        if ({busy1, proc_hold1, done1} !== 3'b100) begin
            n_err++;
            $display("FAIL clean_run_entry: got busy/hold/done=%b expected 100", {busy1, proc_hold1, done1});
        end
        n_vec++;
        if (rs1_out1 !== 5'd13) begin
            n_err++;
            $display("FAIL clean_run_rs1: got %0d expected 13", rs1_out1);
        end
        wait_done();
        n_vec++;
        if (timed_out !== 1'b0) begin
            n_err++;
            $display("FAIL clean_timeout: got timeout=%0d expected 0", timed_out);
        end
        n_vec++;
        if (busy_cnt !== 36) begin
            n_err++;
            $display("FAIL clean_busy_cycles: got %0d expected 36", busy_cnt);
        end
        n_vec++;
        if ({done1, pass1, proc_hold1} !== 3'b111) begin
            n_err++;
            $display("FAIL clean_done_pass_hold: got %b expected 111", {done1, pass1, proc_hold1});
        end
        n_vec++;
        if (error_count1 !== 6'd0) begin
            n_err++;
            $display("FAIL clean_err_count: got %0d expected 0", error_count1);
        end
        n_vec++;
        if (fail_cnt1 !== 0) begin
            n_err++;
            $display("FAIL clean_fail_strobes: got %0d expected 0", fail_cnt1);
        end
        n_vec++;
        if (rs1_out1 !== 5'd31) begin
            n_err++;
            $display("FAIL clean_index_hold: got %0d expected 31", rs1_out1);
        end
    endtask

    task automatic test_single_mismatch();
        reg_mem[5] = 32'd9;
        fill_rom();
        rom[5] = 32'd7;
        pulse_start(1'b1, 1'b0, 10'd2);
        n_vec++;
        if ({busy1, done1, proc_hold1} !== 3'b100) begin
            n_err++;
            $display("FAIL mis_restart: got busy/done/hold=%b expected 100", {busy1, done1, proc_hold1});
        end
        wait_done();
        n_vec++;
        if (busy_cnt !== 35 || timed_out) begin
            n_err++;
            $display("FAIL mis_busy_cycles: got %0d (timeout %0d) expected 35", busy_cnt, timed_out);
        end
        n_vec++;
        if (fail_cnt1 !== 1) begin
            n_err++;
            $display("FAIL mis_strobe_count: got %0d expected 1", fail_cnt1);
        end
        n_vec++;
        if (last_reg1 !== 5'd5) begin
            n_err++;
            $display("FAIL mis_fail_reg: got %0d expected 5", last_reg1);
        end
        n_vec++;
        if (last_act1 !== 32'd9) begin
            n_err++;
            $display("FAIL mis_fail_act: got %0h expected 9", last_act1);
        end
        n_vec++;
        if ({error_count1, pass1} !== {6'd1, 1'b0}) begin
            n_err++;
            $display("FAIL mis_count_pass: got %0d/%0d expected 1/0", error_count1, pass1);
        end
    endtask

    task automatic test_saturation();
        fill_rom();
        rom[2]  = rom[2]  ^ 32'h100;
        rom[5]  = rom[5]  ^ 32'h100;
        rom[9]  = rom[9]  ^ 32'h100;
        rom[17] = rom[17] ^ 32'h100;
        rom[30] = rom[30] ^ 32'h100;
        pulse_start(1'b1, 1'b1, 10'd1);
        wait_done();
        n_vec++;
        if (timed_out !== 1'b0) begin
            n_err++;
            $display("FAIL sat_timeout: got timeout=%0d expected 0", timed_out);
        end
        n_vec++;
        if (error_count1 !== 6'd5) begin
            n_err++;
            $display("FAIL sat_wide_count: got %0d expected 5", error_count1);
        end
        n_vec++;
        if (error_count2 !== 2'd3) begin
            n_err++;
            $display("FAIL sat_narrow_count: got %0d expected 3", error_count2);
        end
        n_vec++;
        if ({done2, pass2, pass1} !== 3'b100) begin
            n_err++;
            $display("FAIL sat_done_pass: got done2/pass2/pass1=%b expected 100", {done2, pass2, pass1});
        end
        n_vec++;
        if (fail_cnt1 !== 5 || fail_cnt2 !== 5) begin
            n_err++;
            $display("FAIL sat_strobes: got %0d/%0d expected 5/5", fail_cnt1, fail_cnt2);
        end
    endtask

    task automatic test_reset_mid_scan();
        // ROM still holds the five mismatches from the saturation run
        pulse_start(1'b1, 1'b0, 10'd0);
        repeat (19) @(negedge clock);
        n_vec++;
        if (error_count1 !== 6'd4) begin
            n_err++;
            $display("FAIL midscan_partial_count: got %0d expected 4", error_count1);
        end
        proc_rs1 = 5'd22;
        reset_n  = 1'b0;
        #1;
        n_vec++;
        if ({busy1, done1, pass1, proc_hold1, fail_valid1} !== 5'b0) begin
            n_err++;
            $display("FAIL midscan_status: got %b expected 00000", {busy1, done1, pass1, proc_hold1, fail_valid1});
        end
        n_vec++;
        if ({error_count1, fail_reg1, fail_act1, exp_addr1} !== '0) begin
            n_err++;
            $display("FAIL midscan_values: got cnt %0d reg %0d act %0h addr %0d expected all 0", error_count1, fail_reg1, fail_act1, exp_addr1);
        end
        n_vec++;
        if (rs1_out1 !== 5'd22) begin
            n_err++;
            $display("FAIL midscan_rs1: got %0d expected 22", rs1_out1);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({busy1, done1, proc_hold1} !== 3'b000) begin
            n_err++;
            $display("FAIL midscan_after_release: got %b expected 000", {busy1, done1, proc_hold1});
        end
    endtask

    task automatic test_zero_cycles_restart();
        fill_rom();
        pulse_start(1'b1, 1'b0, 10'd0);
        n_vec++;
        if ({busy1, proc_hold1} !== 2'b11) begin
            n_err++;
            $display("FAIL zero_scan_entry: got busy/hold=%b expected 11", {busy1, proc_hold1});
        end
        n_vec++;
        if (rs1_out1 !== 5'd0 || exp_addr1 !== 5'd0) begin
            n_err++;
            $display("FAIL zero_first_index: got %0d/%0d expected 0/0", rs1_out1, exp_addr1);
        end
        @(negedge clock);
        n_vec++;
        if (rs1_out1 !== 5'd1) begin
            n_err++;
            $display("FAIL zero_second_index: got %0d expected 1", rs1_out1);
        end
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        n_vec++;
        if (rs1_out1 !== 5'd2) begin
            n_err++;
            $display("FAIL zero_start_ignored: got index %0d expected 2", rs1_out1);
        end
        wait_done();
        n_vec++;
        if (busy_cnt !== 31 || timed_out) begin
            n_err++;
            $display("FAIL zero_busy_cycles: got %0d (timeout %0d) expected 31", busy_cnt, timed_out);
        end
        n_vec++;
        if ({pass1, error_count1} !== {1'b1, 6'd0}) begin
            n_err++;
            $display("FAIL zero_pass: got %0d/%0d expected 1/0", pass1, error_count1);
        end
        repeat (5) @(negedge clock);
        n_vec++;
        if ({done1, busy1} !== 2'b10) begin
            n_err++;
            $display("FAIL zero_single_done: got done/busy=%b expected 10", {done1, busy1});
        end
    endtask

    task automatic test_start_at_last_compare();
        fill_rom();
        pulse_start(1'b1, 1'b0, 10'd0);
        repeat (32) @(negedge clock);
        // This is scan cycle 32: the coming edge performs the final compare
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        n_vec++;
        if ({done1, busy1, pass1} !== 3'b101) begin
            n_err++;
            $display("FAIL lastcmp_start: got done/busy/pass=%b expected 101", {done1, busy1, pass1});
        end
        repeat (3) @(negedge clock);
        n_vec++;
        if ({done1, busy1} !== 2'b10) begin
            n_err++;
            $display("FAIL lastcmp_stays_done: got done/busy=%b expected 10", {done1, busy1});
        end
    endtask

`ifdef REGCHK_MASK_EN
    task automatic test_mask();
        reg_mem[7] = 32'hFF;
        fill_rom();
        rom[7]      = 32'h0F;
        mask_rom[7] = 32'h0F;
        pulse_start(1'b1, 1'b0, 10'd1);
        wait_done();
        n_vec++;
        if (fail_cnt1 !== 0 || pass1 !== 1'b1 || timed_out) begin
            n_err++;
            $display("FAIL mask_dontcare: got strobes %0d pass %0d expected 0/1", fail_cnt1, pass1);
        end
        mask_rom[7] = 32'hFF;
        pulse_start(1'b1, 1'b0, 10'd1);
        wait_done();
        n_vec++;
        if (fail_cnt1 !== 1 || last_reg1 !== 5'd7 || last_act1 !== 32'hFF) begin
            n_err++;
            $display("FAIL mask_full: got strobes %0d reg %0d act %0h expected 1/7/ff", fail_cnt1, last_reg1, last_act1);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NR; i++) begin
            reg_mem[i] = (i == 0) ? 32'd0 : (32'hA5A5_0000 + 32'(i) * 32'h0000_0101);
        end
        fill_rom();
        repeat (2) @(negedge clock);
        test_reset();
        @(negedge clock);
        reset_n = 1'b1;
        test_clean_run();
        test_single_mismatch();
        test_saturation();
        test_reset_mid_scan();
        test_zero_cycles_restart();
        test_start_at_last_compare();
`ifdef REGCHK_MASK_EN
        test_mask();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit in case a wait never returns
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
